code_lock_ctrl: RTL and testbench



---
 rtl/code_lock_pkg.sv | 21 ++
 rtl/key_entry_buf.sv | 85 ++++++++
 rtl/code_lock_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// Shared definitions for the keypad code-lock controller: key codes, FSM states and a
// digit-validity helper.
package code_lock_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_STAR  = 4'hB;

  typedef enum logic [2:0] {
    StLocked,
    StOpen,
    StNew1,
    StNew2,
    StSetm,
    StLockout
  } lock_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/key_entry_buf.sv
// Keypad entry buffer: rising-edge key accept, digit storage with overflow tracking and a
// one-cycle terminator strobe. The buffer clears on the cycle after a terminator.
module key_entry_buf
  import code_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [3:0]            key_i,
  input  logic                  valid_i,
  input  logic                  freeze_i,    // drop all keys and clear the buffer
  input  logic                  digit_en_i,  // digits are stored only when set
  output logic [CODE_LEN*4-1:0] entry_o,
  output logic                  well_formed_o,
  output logic                  term_enter_o,
  output logic                  term_star_o
);

  localparam int unsigned CntW = $clog2(CODE_LEN + 1);

  logic                  valid_prev_q;
  logic [CODE_LEN*4-1:0] entry_q, entry_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  enter_q, enter_d;
  logic                  star_q, star_d;
  logic                  accept;

  assign accept = valid_i & ~valid_prev_q & ~freeze_i;

  // Next-state for the buffer: clear after a terminator or while frozen, else absorb a key
  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    enter_d = 1'b0;
    star_d  = 1'b0;
    if (freeze_i || enter_q || star_q) begin
      entry_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      if (key_i == KEY_ENTER) begin
        enter_d = 1'b1;
      end else if (key_i == KEY_STAR) begin
        star_d = 1'b1;
      end else if (is_digit(key_i) && digit_en_i) begin
        if (cnt_q < CntW'(CODE_LEN)) begin
          for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (cnt_q == CntW'(i)) entry_d[i*4 +: 4] = key_i;
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // Buffer and edge-detect registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_prev_q <= 1'b0;
      entry_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      enter_q      <= 1'b0;
      star_q       <= 1'b0;
    end else begin
      valid_prev_q <= valid_i;
      entry_q      <= entry_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      enter_q      <= enter_d;
      star_q       <= star_d;
    end
  end

  assign entry_o       = entry_q;
  assign well_formed_o = (cnt_q == CntW'(CODE_LEN)) && !ovf_q;
  assign term_enter_o  = enter_q;
  assign term_star_o   = star_q;

endmodule

// File: rtl/code_lock_ctrl.sv
// Parametrised keypad code-lock controller: FSM, stored code, change candidate, shared
// OPEN/LOCKOUT timer and wrong-code counter. Define CODE_LOCK_LOCKOUT_EN to enable the
// lockout after MAX_WRONG consecutive wrong codes.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int unsigned           CODE_LEN       = 4,
  parameter int unsigned           MAX_WRONG      = 3,
  parameter int unsigned           OPEN_CYCLES    = 1000,
  parameter int unsigned           LOCKOUT_CYCLES = 5000,
  parameter logic [CODE_LEN*4-1:0] INIT_CODE      = 16'h2342
) (
  input  logic                  clk,
  input  logic                  reset_1,
  input  logic [3:0]            Code_1,
  input  logic                  Valid_1,
  input  logic                  set,
  output logic                  OPEN,
  output logic                  LOCK,
  output logic                  SAVE_LIGHT,
  output logic                  SET,
  output logic                  CHANGE,
  output logic                  LOCKOUT,
  output logic [CODE_LEN*4-1:0] data_1,
  output logic [3:0]            count_Wrong
);

  localparam int unsigned CodeW    = CODE_LEN * 4;
  localparam int unsigned TimerMax = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                     : LOCKOUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax) + 1;
  localparam logic [TimerW-1:0] OpenLast    = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] LockoutLast = TimerW'(LOCKOUT_CYCLES - 1);

  lock_state_t       state_q, state_d;
  logic [3:0]        wrong_q, wrong_d, wrong_inc;
  logic [CodeW-1:0]  stored_q, stored_d;
  logic [CodeW-1:0]  cand_q, cand_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              open_q, lock_q, save_q, set_q, change_q;
  logic              reload;

  logic [CodeW-1:0]  entry;
  logic              well_formed, term_enter, term_star, term, match_stored, freeze;

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam bit LockoutEn = 1'b1;
  logic lockout_q;

  // Lockout indicator registered from next state
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) lockout_q <= 1'b0;
    else          lockout_q <= (state_d == StLockout);
  end

  assign LOCKOUT = lockout_q;
`else
  localparam bit LockoutEn = 1'b0;
  assign LOCKOUT = 1'b0;
`endif

  assign freeze = set || (state_q == StSetm) || (state_q == StLockout);

  key_entry_buf #(
    .CODE_LEN(CODE_LEN)
  ) u_entry (
    .clk_i        (clk),
    .rst_ni       (reset_1),
    .key_i        (Code_1),
    .valid_i      (Valid_1),
    .freeze_i     (freeze),
    .digit_en_i   (state_q != StOpen),
    .entry_o      (entry),
    .well_formed_o(well_formed),
    .term_enter_o (term_enter),
    .term_star_o  (term_star)
  );

  assign term         = term_enter | term_star;
  assign match_stored = well_formed && (entry == stored_q);
  assign wrong_inc    = (wrong_q == 4'hF) ? 4'hF : wrong_q + 4'd1;

  // FSM next state, code/candidate updates, wrong counter and shared timer
  always_comb begin
    state_d  = state_q;
    wrong_d  = wrong_q;
    stored_d = stored_q;
    cand_d   = cand_q;
    reload   = 1'b0;
    // set overrides any pending terminator so that entry is never scored
    if (set && (state_q != StLockout)) begin
      state_d = StSetm;
      cand_d  = '0;
    end else begin
      unique case (state_q)
        StLocked: begin
          if (term) begin
            if (match_stored) begin
              wrong_d = 4'd0;
              state_d = term_enter ? StOpen : StNew1;
            end else begin
              wrong_d = wrong_inc;
              if (LockoutEn && (wrong_inc >= 4'(MAX_WRONG))) state_d = StLockout;
            end
          end
        end
        StOpen: begin
          if (term_enter)               reload  = 1'b1;
          else if (timer_q == OpenLast) state_d = StLocked;
        end
        StNew1: begin
          if (term_enter && well_formed) begin
            cand_d  = entry;
            state_d = StNew2;
          end else if (term_star) begin
            state_d = StLocked;
          end
        end
        StNew2: begin
          if (term_enter) begin
            if (well_formed && (entry == cand_q)) begin
              stored_d = cand_q;
              state_d  = StLocked;
            end else begin
              state_d = StNew1;
            end
            cand_d = '0;
          end else if (term_star) begin
            state_d = StLocked;
            cand_d  = '0;
          end
        end
        StSetm: state_d = StNew1;
        StLockout: begin
          if (timer_q == LockoutLast) begin
            state_d = StLocked;
            wrong_d = 4'd0;
          end
        end
        default: state_d = StLocked;
      endcase
    end
    // Timer runs only in OPEN/LOCKOUT and restarts on any state change or reload
    if ((state_d != state_q) || reload ||
        !((state_q == StOpen) || (state_q == StLockout))) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // State, code, counter and timer registers
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      state_q  <= StLocked;
      wrong_q  <= 4'd0;
      stored_q <= INIT_CODE;
      cand_q   <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      wrong_q  <= wrong_d;
      stored_q <= stored_d;
      cand_q   <= cand_d;
      timer_q  <= timer_d;
    end
  end

  // Indicator outputs registered from next state
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      open_q   <= 1'b0;
      lock_q   <= 1'b1;
      save_q   <= 1'b0;
      set_q    <= 1'b0;
      change_q <= 1'b0;
    end else begin
      open_q   <= (state_d == StOpen);
      lock_q   <= (state_d != StOpen);
      save_q   <= (state_d == StNew1) || (state_d == StNew2);
      set_q    <= (state_d == StSetm);
      change_q <= (state_d == StNew2);
    end
  end

  assign OPEN        = open_q;
  assign LOCK        = lock_q;
  assign SAVE_LIGHT  = save_q;
  assign SET         = set_q;
  assign CHANGE      = change_q;
  assign data_1      = entry;
  assign count_Wrong = wrong_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: a key-level behavioural model checked against the DUT on every
// cycle, plus directed scenarios with literal expectations. INIT_CODE 16'h2432 makes the
// key sequence 2,3,4,2 the reset code (first digit at [3:0]).
module tb_code_lock_ctrl;

  localparam int CL = 4;
  localparam int MW = 3;
  localparam int OC = 20;
  localparam int LC = 30;
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int M_LOCKED  = 0;
  localparam int M_OPEN    = 1;
  localparam int M_NEW1    = 2;
  localparam int M_NEW2    = 3;
  localparam int M_SETM    = 4;
  localparam int M_LOCKOUT = 5;

  logic        clk, reset_1, Valid_1, set;
  logic [3:0]  Code_1;
  logic        OPEN, LOCK, SAVE_LIGHT, SET, CHANGE, LOCKOUT;
  logic [15:0] data_1;
  logic [3:0]  count_Wrong;

  int n_checks = 0;
  int n_fail   = 0;

  code_lock_ctrl #(
    .CODE_LEN      (CL),
    .MAX_WRONG     (MW),
    .OPEN_CYCLES   (OC),
    .LOCKOUT_CYCLES(LC),
    .INIT_CODE     (16'h2432)
  ) dut (
    .clk        (clk),
    .reset_1    (reset_1),
    .Code_1     (Code_1),
    .Valid_1    (Valid_1),
    .set        (set),
    .OPEN       (OPEN),
    .LOCK       (LOCK),
    .SAVE_LIGHT (SAVE_LIGHT),
    .SET        (SET),
    .CHANGE     (CHANGE),
    .LOCKOUT    (LOCKOUT),
    .data_1     (data_1),
    .count_Wrong(count_Wrong)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode, digit queue, pending terminator (0 none, 1 '#', 2 '*'),
  // remaining timer cycles and codes held as digit arrays.
  int m_mode, m_left, m_wrong, m_pend;
  int m_entry[$];
  bit m_ovf, m_prev_valid;
  int m_code[CL];
  int m_cand[CL];
  int t_old;
  bit t_frz, t_acc, t_wf;

  function automatic bit entry_equals(input int ref_code[CL]);
    if (m_entry.size() != CL) return 1'b0;
    for (int i = 0; i < CL; i++) if (m_entry[i] != ref_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] packed_entry();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < m_entry.size(); i++) v[i*4 +: 4] = 4'(m_entry[i]);
    return v;
  endfunction

  always @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      m_mode = M_LOCKED; m_left = 0; m_wrong = 0; m_pend = 0;
      m_entry.delete(); m_ovf = 0; m_prev_valid = 0;
      m_code = '{2, 3, 4, 2};
      m_cand = '{0, 0, 0, 0};
    end else begin
      t_old = m_mode;
      t_frz = set || t_old == M_SETM || t_old == M_LOCKOUT;
      t_acc = Valid_1 && !m_prev_valid && !t_frz;
      m_prev_valid = Valid_1;
      t_wf = (m_entry.size() == CL) && !m_ovf;
      if (set && t_old != M_LOCKOUT) begin
        m_mode = M_SETM;
      end else begin
        case (t_old)
          M_LOCKED: if (m_pend != 0) begin
            if (t_wf && entry_equals(m_code)) begin
              m_wrong = 0;
              if (m_pend == 1) begin m_mode = M_OPEN; m_left = OC; end
              else m_mode = M_NEW1;
            end else begin
              if (m_wrong < 15) m_wrong++;
              if (LOCK_EN && m_wrong >= MW) begin m_mode = M_LOCKOUT; m_left = LC; end
            end
          end
          M_OPEN: begin
            if (m_pend == 1) m_left = OC;
            else begin
              m_left--;
              if (m_left == 0) m_mode = M_LOCKED;
            end
          end
          M_NEW1: begin
            if (m_pend == 1 && t_wf) begin
              for (int i = 0; i < CL; i++) m_cand[i] = m_entry[i];
              m_mode = M_NEW2;
            end else if (m_pend == 2) m_mode = M_LOCKED;
          end
          M_NEW2: begin
            if (m_pend == 1) begin
              if (t_wf && entry_equals(m_cand)) begin
                m_code = m_cand;
                m_mode = M_LOCKED;
              end else m_mode = M_NEW1;
            end else if (m_pend == 2) m_mode = M_LOCKED;
          end
          M_SETM: m_mode = M_NEW1;
          M_LOCKOUT: begin
            m_left--;
            if (m_left == 0) begin m_mode = M_LOCKED; m_wrong = 0; end
          end
          default: m_mode = M_LOCKED;
        endcase
      end
      if (m_pend != 0 || t_frz) begin
        m_entry.delete(); m_ovf = 0; m_pend = 0;
      end else if (t_acc) begin
        if (Code_1 == 4'hA) m_pend = 1;
        else if (Code_1 == 4'hB) m_pend = 2;
        else if (Code_1 <= 4'd9 && t_old != M_OPEN) begin
          if (m_entry.size() < CL) m_entry.push_back(int'(Code_1));
          else m_ovf = 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  logic [25:0] exp_v, got_v;
  always @(negedge clk) begin
    exp_v = {m_mode == M_OPEN, m_mode != M_OPEN, (m_mode == M_NEW1 || m_mode == M_NEW2),
             m_mode == M_SETM, m_mode == M_NEW2, m_mode == M_LOCKOUT, packed_entry(),
             4'(m_wrong)};
    got_v = {OPEN, LOCK, SAVE_LIGHT, SET, CHANGE, LOCKOUT, data_1, count_Wrong};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL per_cycle @%0t: got open/lock/save/set/chg/lko=%b data=%h wrong=%0d, want %b data=%h wrong=%0d",
               $time, got_v[25:20], got_v[19:4], got_v[3:0], exp_v[25:20], exp_v[19:4],
               exp_v[3:0]);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    Code_1  = k;
    Valid_1 = 1'b1;
    @(negedge clk);
    Valid_1 = 1'b0;
    @(negedge clk);
  endtask

  // Keys packed one per nibble, first key at [3:0]
  task automatic enter_keys(input logic [31:0] keys, input int n);
    for (int i = 0; i < n; i++) press(keys[i*4 +: 4]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 0; reset_1 = 0; Code_1 = 0; Valid_1 = 0; set = 0;
    wait_cycles(3);
    check("reset_lock", LOCK, 1);
    check("reset_open", OPEN, 0);
    check("reset_save", SAVE_LIGHT, 0);
    check("reset_data", data_1, 0);
    check("reset_wrong", count_Wrong, 0);
    reset_1 = 1;

    // Correct code opens, then relocks after OC cycles
    enter_keys(32'h0432, 3);
    check("partial_data", data_1, 16'h0432);
    enter_keys(32'hA2, 2);
    check("open_after_code", OPEN, 1);
    check("unlock_after_code", LOCK, 0);
    check("data_clear_open", data_1, 0);
    wait_cycles(OC - 1);
    check("open_held", OPEN, 1);
    wait_cycles(1);
    check("open_expired", LOCK, 1);
    check("wrong_zero", count_Wrong, 0);

    // Three wrong codes
    for (int i = 1; i <= 3; i++) begin
      enter_keys(32'hA1111, 5);
      check("wrong_count", count_Wrong, i);
    end
    check("model_wrong", m_wrong, 3);
`ifdef CODE_LOCK_LOCKOUT_EN
    check("lockout_set", LOCKOUT, 1);
    enter_keys(32'hA2432, 5);
    check("lockout_ignores_open", OPEN, 0);
    wait_cycles(LC - 16);
    check("lockout_held", LOCKOUT, 1);
    wait_cycles(1);
    check("lockout_over", LOCKOUT, 0);
    check("lockout_wrong_clr", count_Wrong, 0);
`else
    check("no_lockout", LOCKOUT, 0);
    enter_keys(32'hA2432, 5);
    check("open_no_lockout", OPEN, 1);
    check("wrong_clr_open", count_Wrong, 0);
    wait_cycles(OC);
`endif

    // Confirm mismatch keeps the old code; '#' in OPEN reloads the timer
    enter_keys(32'hB2432, 5);
    check("save_light", SAVE_LIGHT, 1);
    enter_keys(32'hA8765, 5);
    check("change_on", CHANGE, 1);
    enter_keys(32'hA9765, 5);
    check("change_off_mismatch", CHANGE, 0);
    check("back_new1", SAVE_LIGHT, 1);
    enter_keys(32'hB, 1);
    check("abort_locked", SAVE_LIGHT, 0);
    enter_keys(32'hA2432, 5);
    check("old_code_opens", OPEN, 1);
    wait_cycles(10);
    enter_keys(32'hA, 1);
    wait_cycles(OC - 1);
    check("reload_held", OPEN, 1);
    wait_cycles(1);
    check("reload_expired", OPEN, 0);

    // Full code change to 5,6,7,8
    enter_keys(32'hB2432, 5);
    enter_keys(32'hA8765, 5);
    check("change_on2", CHANGE, 1);
    enter_keys(32'hA8765, 5);
    check("changed_save_off", SAVE_LIGHT, 0);
    check("changed_locked", LOCK, 1);
    check("model_code0", m_code[0], 5);
    enter_keys(32'hA8765, 5);
    check("new_code_opens", OPEN, 1);
    wait_cycles(OC);
    enter_keys(32'hA2432, 5);
    check("old_code_wrong", count_Wrong, 1);
    check("old_code_closed", OPEN, 0);

    // Malformed entries: short and overlong
    enter_keys(32'hA8765, 5);
    check("reopen_clears", count_Wrong, 0);
    wait_cycles(OC);
    enter_keys(32'h432, 3);
    enter_keys(32'hA, 1);
    check("short_wrong", count_Wrong, 1);
    check("short_data_clr", data_1, 0);
    enter_keys(32'h12432, 5);
    check("overflow_data", data_1, 16'h2432);
    enter_keys(32'hA, 1);
    check("long_wrong", count_Wrong, 2);
    check("long_data_clr", data_1, 0);

    // Service override mid-entry
    enter_keys(32'h32, 2);
    check("set_pre_data", data_1, 16'h0032);
    @(negedge clk); set = 1;
    @(negedge clk);
    check("set_active", SET, 1);
    check("set_data_clr", data_1, 0);
    set = 0;
    @(negedge clk);
    check("set_fall_new1", SAVE_LIGHT, 1);
    check("set_fall_set_off", SET, 0);
    enter_keys(32'hB, 1);

    // set on the accept edge of '#'
    enter_keys(32'h1111, 4);
    @(negedge clk); Code_1 = 4'hA; Valid_1 = 1; set = 1;
    @(negedge clk); Valid_1 = 0; set = 0;
    @(negedge clk);
    check("set_vs_accept_wrong", count_Wrong, 2);
    check("set_vs_accept_new1", SAVE_LIGHT, 1);
    enter_keys(32'hB, 1);

    // set on the verdict edge
    enter_keys(32'h1111, 4);
    @(negedge clk); Code_1 = 4'hA; Valid_1 = 1;
    @(negedge clk); Valid_1 = 0; set = 1;
    @(negedge clk); set = 0;
    check("set_vs_verdict_wrong", count_Wrong, 2);
    check("set_vs_verdict_set", SET, 1);
    enter_keys(32'hB, 1);
    check("set_vs_verdict_locked", SAVE_LIGHT, 0);

    // Reset mid-entry restores the initial code
    enter_keys(32'h32, 2);
    @(negedge clk); reset_1 = 0;
    #2;
    check("rst_data", data_1, 0);
    check("rst_wrong", count_Wrong, 0);
    check("rst_lock", LOCK, 1);
    @(negedge clk); reset_1 = 1;
    enter_keys(32'hA2432, 5);
    check("init_code_after_rst", OPEN, 1);
    wait_cycles(OC);
    check("final_locked", LOCK, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
